// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: runs a shift of up to 31 bits as a series of
// bounded steps (at most MAX_STEP bits per clock) behind a Start/Busy/Done handshake.
// Optional feature macro: SHIFT_SEQUENCER_ROTATE_EN. Mode 11 is rotate right when it is
// defined, and an alias of logical right when it is not.

module shift_sequencer #(
   parameter int WIDTH    = 16,
   parameter int MAX_STEP = 7
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [1:0]       Mode,
   input  logic [4:0]       Amount,
   input  logic [WIDTH-1:0] Data_In,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Result
);

   localparam logic [4:0] WIDTH_AMT = 5'(WIDTH);
   localparam logic [4:0] STEP_MAX  = 5'(MAX_STEP);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   state_t             state_r;
   state_t             next_state_s;
   logic [WIDTH-1:0]   acc_r;
   logic [4:0]         rem_r;
   logic [1:0]         mode_r;
   logic [WIDTH-1:0]   result_r;
   logic               busy_r;
   logic               done_r;

   logic               accept_s;
   logic [1:0]         eff_mode_s;
   logic [4:0]         eff_amt_s;
   logic [4:0]         step_s;
   logic [4:0]         rem_next_s;
   logic [WIDTH-1:0]   shifted_s;
   logic               last_step_s;

   // One bounded shift step of v by s bits in mode m.
   function automatic logic [WIDTH-1:0] shift_step(
      input logic [WIDTH-1:0] v,
      input logic [1:0]       m,
      input logic [4:0]       s
   );
`ifdef SHIFT_SEQUENCER_ROTATE_EN
      logic [2*WIDTH-1:0] rot;
`endif
      logic [WIDTH-1:0] res;
      res = v >> s;
      case (m)
         2'b00:   res = v << s;
         2'b01:   res = v >> s;
         2'b10:   res = WIDTH'($signed(v) >>> s);
`ifdef SHIFT_SEQUENCER_ROTATE_EN
         2'b11: begin
            rot = {v, v} >> s;
            res = rot[WIDTH-1:0];
         end
`endif
         default: res = v >> s;
      endcase
      return res;
   endfunction

   // Request decode: effective mode and amount captured on the accepting edge.
   always_comb begin
      accept_s   = Start && (state_r != ST_RUN);
      eff_mode_s = Mode;
      eff_amt_s  = Amount;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
      if (Mode == 2'b11) begin
         eff_amt_s = Amount % WIDTH_AMT;
      end else if (Amount > WIDTH_AMT) begin
         eff_amt_s = WIDTH_AMT;
      end else begin
         eff_amt_s = Amount;
      end
`else
      if (Mode == 2'b11) begin
         eff_mode_s = 2'b01;
      end else begin
         eff_mode_s = Mode;
      end
      if (Amount > WIDTH_AMT) begin
         eff_amt_s = WIDTH_AMT;
      end else begin
         eff_amt_s = Amount;
      end
`endif
   end

   // Step datapath: clamp the remaining amount to one stage and shift the accumulator.
   always_comb begin
      step_s = rem_r;
      if (rem_r > STEP_MAX) begin
         step_s = STEP_MAX;
      end else begin
         step_s = rem_r;
      end
      rem_next_s  = rem_r - step_s;
      shifted_s   = shift_step(acc_r, mode_r, step_s);
      last_step_s = (rem_next_s == 5'd0);
   end

   // Next-state logic; DONE accepts a new request so back-to-back shifts have no bubble.
   always_comb begin
      next_state_s = ST_IDLE;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (accept_s && (eff_amt_s == 5'd0)) begin
               next_state_s = ST_DONE;
            end else if (accept_s) begin
               next_state_s = ST_RUN;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (last_step_s) begin
               next_state_s = ST_DONE;
            end else begin
               next_state_s = ST_RUN;
            end
         end
         default: next_state_s = ST_IDLE;
      endcase
   end

   // State, operand and registered handshake/result outputs.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_r  <= ST_IDLE;
         acc_r    <= '0;
         rem_r    <= 5'd0;
         mode_r   <= 2'b00;
         result_r <= '0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state_r <= next_state_s;
         busy_r  <= (next_state_s == ST_RUN);
         done_r  <= (next_state_s == ST_DONE);
         if (accept_s) begin
            acc_r  <= Data_In;
            mode_r <= eff_mode_s;
            rem_r  <= eff_amt_s;
            if (eff_amt_s == 5'd0) begin
               result_r <= Data_In;
            end
         end else if (state_r == ST_RUN) begin
            acc_r <= shifted_s;
            rem_r <= rem_next_s;
            // Result is only exposed on the completing step, never mid-shift.
            if (last_step_s) begin
               result_r <= shifted_s;
            end
         end
      end
   end

   assign Busy   = busy_r;
   assign Done   = done_r;
   assign Result = result_r;

endmodule
